stack_sequencer: RTL and testbench

Multi-cycle stack engine for the MOSby 6502 core. It sits between the register file and the memory bus:
- On push operations it reads register values (A, P, PC) and writes them to page $01 at the stack pointer.
- On pull operations it reads bytes from page $01 and returns them to the register file through write strobes.

It owns the stack pointer arithmetic and commits the updated SP in the same cycle as the pulled data.

---
 rtl/mos_pkg.sv | 41 ++++
 rtl/stack_sequencer_if.sv | 20 ++
 rtl/stack_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mos_pkg.sv
// Shared MOSby types: stack op encoding, stack page, P bits
// and the stack sequencer's state and byte-select enums.
package mos_pkg;

   typedef enum logic [2:0] {
      OP_PHA      = 3'd0,
      OP_PHP      = 3'd1,
      OP_PLA      = 3'd2,
      OP_PLP      = 3'd3,
      OP_PUSH_PC  = 3'd4,
      OP_PULL_PC  = 3'd5,
      OP_PUSH_INT = 3'd6,
      OP_PULL_INT = 3'd7
   } stack_op_t;

   localparam logic [7:0] STACK_PAGE = 8'h01;
   localparam int P_B = 4;
   localparam int P_U = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_DONE
   } seq_state_t;

   typedef enum logic [2:0] {
      SEL_A,
      SEL_P,
      SEL_PHP,
      SEL_PINT,
      SEL_PCL,
      SEL_PCH
   } byte_sel_t;

   typedef struct packed {
      logic      push;
      logic      last;
      byte_sel_t sel;
   } step_t;

endpackage

// File: rtl/stack_sequencer_if.sv
// Byte-wide memory bus between the stack sequencer
// (master) and the memory system (slave).
interface stack_sequencer_if;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_addr, mem_wdata, mem_we, mem_re,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_we, mem_re,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/stack_sequencer.sv
// Multi-cycle stack engine: pushes/pulls A, P and PC through
// page STACK_PAGE and commits SP with the pulled data.
module stack_sequencer #(
   parameter logic [7:0] STACK_PAGE = mos_pkg::STACK_PAGE
) (
   input  logic        clk_2,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic        brk,
   input  logic [7:0]  sp_in,
   input  logic [7:0]  a_in,
   input  logic [7:0]  p_in,
   input  logic [15:0] pc_in,
   stack_sequencer_if.master mem,
   output logic        busy,
   output logic        done,
   output logic        sp_wr,
   output logic        a_wr,
   output logic        p_wr,
   output logic        pc_wr,
   output logic [7:0]  sp_wdata,
   output logic [7:0]  a_wdata,
   output logic [7:0]  p_wdata,
   output logic [15:0] pc_wdata
);
   import mos_pkg::*;

   seq_state_t  state_q, state_d;
   stack_op_t   op_q, op_d;
   logic        brk_q, brk_d;
   logic [7:0]  sp_q, sp_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  p_q, p_d;
   logic [15:0] pc_q, pc_d;
   logic [1:0]  idx_q, idx_d;

   step_t      step;
   logic [7:0] sp_inc;
   logic [7:0] pdata;

   // Byte order per op; idx selects the byte within the op.
   function automatic step_t step_of(
      input stack_op_t o,
      input logic [1:0] i
   );
      step_t s;
      s.push = 1'b0;
      s.last = 1'b1;
      s.sel  = SEL_A;
      unique case (o)
         OP_PHA: begin
            s.push = 1'b1;
            s.sel  = SEL_A;
         end
         OP_PHP: begin
            s.push = 1'b1;
            s.sel  = SEL_PHP;
         end
         OP_PLA: s.sel = SEL_A;
         OP_PLP: s.sel = SEL_P;
         OP_PUSH_PC: begin
            s.push = 1'b1;
            s.last = (i == 2'd1);
            s.sel  = (i == 2'd0) ? SEL_PCH : SEL_PCL;
         end
         OP_PULL_PC: begin
            s.last = (i == 2'd1);
            s.sel  = (i == 2'd0) ? SEL_PCL : SEL_PCH;
         end
         OP_PUSH_INT: begin
            s.push = 1'b1;
            s.last = (i == 2'd2);
            s.sel  = (i == 2'd0) ? SEL_PCH :
                     (i == 2'd1) ? SEL_PCL : SEL_PINT;
         end
         OP_PULL_INT: begin
            s.last = (i == 2'd2);
            s.sel  = (i == 2'd0) ? SEL_P :
                     (i == 2'd1) ? SEL_PCL : SEL_PCH;
         end
         default: ;
      endcase
      return s;
   endfunction

   always_comb begin
      step   = step_of(op_q, idx_q);
      sp_inc = sp_q + 8'd1;
      pdata  = 8'h00;
      unique case (step.sel)
         SEL_A:    pdata = a_q;
         SEL_P:    pdata = p_q;
         SEL_PHP:  pdata = p_q | 8'h30;
         SEL_PINT: pdata = {p_q[7:6], 1'b1, brk_q, p_q[3:0]};
         SEL_PCL:  pdata = pc_q[7:0];
         SEL_PCH:  pdata = pc_q[15:8];
         default:  pdata = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      brk_d   = brk_q;
      sp_d    = sp_q;
      a_d     = a_q;
      p_d     = p_q;
      pc_d    = pc_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_XFER;
               op_d    = stack_op_t'(op);
               brk_d   = brk;
               sp_d    = sp_in;
               a_d     = a_in;
               p_d     = p_in;
               pc_d    = pc_in;
               idx_d   = 2'd0;
            end
         end
         ST_XFER: begin
            if (mem.mem_ready) begin
               idx_d = idx_q + 2'd1;
               if (step.push) begin
                  sp_d = sp_q - 8'd1;
               end else begin
                  sp_d = sp_inc;
                  unique case (step.sel)
                     SEL_A:   a_d = mem.mem_rdata;
                     SEL_P: begin
                        p_d      = mem.mem_rdata;
                        p_d[P_U] = 1'b1;
                        p_d[P_B] = 1'b0;
                     end
                     SEL_PCL: pc_d[7:0]  = mem.mem_rdata;
                     SEL_PCH: pc_d[15:8] = mem.mem_rdata;
                     default: ;
                  endcase
               end
               if (step.last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus and commit outputs decode registered state only.
   always_comb begin
      mem.mem_addr  = 16'h0000;
      mem.mem_wdata = 8'h00;
      mem.mem_we    = 1'b0;
      mem.mem_re    = 1'b0;
      busy     = (state_q != ST_IDLE);
      done     = 1'b0;
      sp_wr    = 1'b0;
      a_wr     = 1'b0;
      p_wr     = 1'b0;
      pc_wr    = 1'b0;
      sp_wdata = 8'h00;
      a_wdata  = 8'h00;
      p_wdata  = 8'h00;
      pc_wdata = 16'h0000;
      if (state_q == ST_XFER) begin
         mem.mem_addr = {STACK_PAGE,
                         step.push ? sp_q : sp_inc};
         mem.mem_we   = step.push;
         mem.mem_re   = !step.push;
         if (step.push) begin
            mem.mem_wdata = pdata;
         end
      end
      if (state_q == ST_DONE) begin
         done     = 1'b1;
         sp_wr    = 1'b1;
         a_wr     = (op_q == OP_PLA);
         p_wr     = (op_q == OP_PLP) ||
                    (op_q == OP_PULL_INT);
         pc_wr    = (op_q == OP_PULL_PC) ||
                    (op_q == OP_PULL_INT);
         sp_wdata = sp_q;
         a_wdata  = a_q;
         p_wdata  = p_q;
         pc_wdata = pc_q;
      end
   end

   always_ff @(posedge clk_2 or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_PHA;
         brk_q   <= 1'b0;
         sp_q    <= 8'h00;
         a_q     <= 8'h00;
         p_q     <= 8'h00;
         pc_q    <= 16'h0000;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         brk_q   <= brk_d;
         sp_q    <= sp_d;
         a_q     <= a_d;
         p_q     <= p_d;
         pc_q    <= pc_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: a page-1 memory
// model answers the bus, queues hold expected accesses/commits.
module tb_stack_sequencer;

   typedef struct {
      bit          we;
      logic [15:0] addr;
      logic [7:0]  data;
   } acc_t;

   typedef struct {
      int          cyc;
      logic        a_wr;
      logic        p_wr;
      logic        pc_wr;
      logic [7:0]  sp;
      logic [7:0]  a;
      logic [7:0]  p;
      logic [15:0] pc;
   } commit_t;

   logic        clk_2 = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic        brk;
   logic [7:0]  sp_in, a_in, p_in;
   logic [15:0] pc_in;
   logic        busy, done;
   logic        sp_wr, a_wr, p_wr, pc_wr;
   logic [7:0]  sp_wdata, a_wdata, p_wdata;
   logic [15:0] pc_wdata;

   stack_sequencer_if bus ();

   stack_sequencer dut (
      .clk_2    (clk_2),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .brk      (brk),
      .sp_in    (sp_in),
      .a_in     (a_in),
      .p_in     (p_in),
      .pc_in    (pc_in),
      .mem      (bus),
      .busy     (busy),
      .done     (done),
      .sp_wr    (sp_wr),
      .a_wr     (a_wr),
      .p_wr     (p_wr),
      .pc_wr    (pc_wr),
      .sp_wdata (sp_wdata),
      .a_wdata  (a_wdata),
      .p_wdata  (p_wdata),
      .pc_wdata (pc_wdata)
   );

   initial forever #5 clk_2 = ~clk_2;

   logic [7:0] mem [0:255];
   acc_t      acc_q [$];
   commit_t   cm_q [$];
   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int waits = 0;
   int wcnt  = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctl"},
          {24'd0, busy, done, bus.mem_we, bus.mem_re,
           sp_wr, a_wr, p_wr, pc_wr}, 32'd0);
      chk({tag, "_addr"}, {16'd0, bus.mem_addr}, 32'd0);
      chk({tag, "_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
      chk({tag, "_rf"}, {8'd0, sp_wdata, a_wdata, p_wdata},
          32'd0);
      chk({tag, "_pc"}, {16'd0, pc_wdata}, 32'd0);
   endtask

   // One clock: check commits, then act as the memory.
   task automatic cycle();
      commit_t c;
      acc_t    e;
      @(negedge clk_2);
      cyc++;
      if (done) begin
         if (cm_q.size() == 0) begin
            chk("extra_done", 32'd1, 32'd0);
         end else begin
            c = cm_q.pop_front();
            chk("done_cyc", 32'(cyc), 32'(c.cyc));
            chk("sp_wr", {31'd0, sp_wr}, 32'd1);
            chk("sp_wdata", {24'd0, sp_wdata}, {24'd0, c.sp});
            chk("a_wr", {31'd0, a_wr}, {31'd0, c.a_wr});
            chk("p_wr", {31'd0, p_wr}, {31'd0, c.p_wr});
            chk("pc_wr", {31'd0, pc_wr}, {31'd0, c.pc_wr});
            if (c.a_wr)
               chk("a_wdata", {24'd0, a_wdata}, {24'd0, c.a});
            if (c.p_wr)
               chk("p_wdata", {24'd0, p_wdata}, {24'd0, c.p});
            if (c.pc_wr)
               chk("pc_wdata", {16'd0, pc_wdata}, {16'd0, c.pc});
         end
      end
      if (rst && (bus.mem_we || bus.mem_re)) begin
         if (wcnt >= waits) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr[7:0]];
            if (acc_q.size() == 0) begin
               chk("extra_access", 32'd1, 32'd0);
            end else begin
               e = acc_q.pop_front();
               chk("acc_we", {31'd0, bus.mem_we}, {31'd0, e.we});
               chk("acc_addr", {16'd0, bus.mem_addr},
                   {16'd0, e.addr});
               if (bus.mem_we)
                  chk("acc_wdata", {24'd0, bus.mem_wdata},
                      {24'd0, e.data});
            end
            if (bus.mem_we)
               mem[bus.mem_addr[7:0]] = bus.mem_wdata;
            wcnt = 0;
         end else begin
            bus.mem_ready = 1'b0;
            wcnt++;
         end
      end else begin
         bus.mem_ready = 1'b0;
         wcnt = 0;
      end
   endtask

   // Reference model: queue expected bytes and commit, then run.
   task automatic run_op(input logic [2:0] o,
                         input logic [7:0] sp,
                         input logic [7:0] a,
                         input logic [7:0] p,
                         input logic [15:0] pc,
                         input logic b,
                         input int w,
                         input bit dup);
      logic [7:0] d [3];
      logic [7:0] ad;
      int n;
      bit push;
      commit_t c;
      d[0] = 8'h00; d[1] = 8'h00; d[2] = 8'h00;
      push = o inside {3'd0, 3'd1, 3'd4, 3'd6};
      n = (o inside {3'd0, 3'd1, 3'd2, 3'd3}) ? 1 :
          (o inside {3'd4, 3'd5}) ? 2 : 3;
      case (o)
         3'd0: d[0] = a;
         3'd1: d[0] = p | 8'h30;
         3'd4: begin d[0] = pc[15:8]; d[1] = pc[7:0]; end
         3'd6: begin
            d[0] = pc[15:8];
            d[1] = pc[7:0];
            d[2] = {p[7:6], 1'b1, b, p[3:0]};
         end
         default: ;
      endcase
      for (int i = 0; i < n; i++) begin
         if (push) begin
            ad = sp - 8'(i);
         end else begin
            ad = sp + 8'(i + 1);
            d[i] = mem[ad];
         end
         acc_q.push_back('{push, {8'h01, ad}, d[i]});
      end
      c.cyc   = cyc + n * (w + 1) + 1;
      c.sp    = push ? sp - 8'(n) : sp + 8'(n);
      c.a_wr  = (o == 3'd2);
      c.p_wr  = (o == 3'd3) || (o == 3'd7);
      c.pc_wr = (o == 3'd5) || (o == 3'd7);
      c.a     = d[0];
      c.p     = {d[0][7:6], 2'b10, d[0][3:0]};
      c.pc    = (o == 3'd5) ? {d[1], d[0]} : {d[2], d[1]};
      cm_q.push_back(c);
      waits = w;
      start = 1'b1;
      op = o; sp_in = sp; a_in = a; p_in = p;
      pc_in = pc; brk = b;
      cycle();
      chk("busy", {31'd0, busy}, 32'd1);
      start = dup;
      op = 3'd2;
      sp_in = 8'h55;
      cycle();
      start = 1'b0;
      for (int k = 0; k < 200 &&
           (acc_q.size() + cm_q.size()) != 0; k++)
         cycle();
      chk("drain", 32'(acc_q.size() + cm_q.size()), 32'd0);
      cycle();
      cycle();
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; op = 3'd0; brk = 1'b0;
      sp_in = 8'h00; a_in = 8'h00; p_in = 8'h00;
      pc_in = 16'h0000;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      cycle();
      cycle();
      chk_quiet("reset");
      rst = 1'b1;
      cycle();

      run_op(3'd0, 8'hFF, 8'h5A, 8'h00, 16'h0000, 1'b0, 0, 1'b0);
      mem[8'h00] = 8'hFF;
      run_op(3'd3, 8'hFF, 8'h00, 8'h00, 16'h0000, 1'b0, 0, 1'b0);
      run_op(3'd6, 8'h01, 8'h00, 8'h00, 16'hABCD, 1'b1, 0, 1'b0);
      chk("int_mem_01", {24'd0, mem[8'h01]}, 32'hAB);
      chk("int_mem_00", {24'd0, mem[8'h00]}, 32'hCD);
      chk("int_mem_ff", {24'd0, mem[8'hFF]}, 32'h30);
      mem[8'hFE] = 8'h34;
      mem[8'hFF] = 8'h12;
      run_op(3'd5, 8'hFD, 8'h00, 8'h00, 16'h0000, 1'b0, 2, 1'b0);

      mem[8'hF1] = 8'hC3;
      mem[8'hF2] = 8'h11;
      mem[8'hF3] = 8'h22;
      acc_q.push_back('{1'b0, 16'h01F1, 8'hC3});
      waits = 2;
      start = 1'b1; op = 3'd7; sp_in = 8'hF0;
      cycle();
      start = 1'b0;
      repeat (3) cycle();
      chk("mid_addr", {16'd0, bus.mem_addr}, 32'h01F2);
      #2 rst = 1'b0;
      #1 chk_quiet("rst_mid");
      chk("rst_acc_q", 32'(acc_q.size()), 32'd0);
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      mem[8'h11] = 8'h77;
      run_op(3'd2, 8'h10, 8'h00, 8'h00, 16'h0000, 1'b0, 1, 1'b0);

      run_op(3'd1, 8'h80, 8'h00, 8'h41, 16'h0000, 1'b0, 0, 1'b1);

      for (int t = 0; t < 8; t++)
         run_op(3'($urandom_range(0, 7)), 8'($urandom),
                8'($urandom), 8'($urandom), 16'($urandom),
                1'($urandom), $urandom_range(0, 2), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
